multi_lane_serializer: RTL and testbench
========================================

Name: multi_lane_serializer

Overview:
- Parametrised successor to the single-lane PISO serializer.
- Serialises CHANNELS parallel words of WIDTH bits each, in lock-step, on one serial-rate clock.
- Generates its own word-boundary load strobe from an internal bit counter, so upstream never sees bit timing.
- Accepts words through a valid/ready handshake with a one-entry holding buffer. Inserts a programmable idle word on underrun.
- Sits between the TMDS encoders and the output pins of the HDMI transmitter.

Parameters:
- WIDTH, 10: bits per word per lane; legal range is 2 or more.
- CHANNELS, 3: number of lanes serialised in lock-step; legal range is 1 or more.
- LSB_FIRST, 1: 1 transmits bit 0 first; 0 transmits bit WIDTH-1 first.
- IDLE_WORD, 10'b1101010100: word loaded into every lane when no data is available.

Ports:
- clk  in  1  serial-rate clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data holds a word for all lanes.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  CHANNELS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- serial_out  out  CHANNELS  current serial bit of each lane.
- word_start  out  1  high while serial_out carries the first bit of a word.
- underrun  out  1  sticky flag: an idle word was inserted.
- underrun_clr  in  1  synchronous clear of underrun.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low. All state updates on posedge clk, or on negedge rst_n.
- Reset values:
  - shift registers all 0; serial_out = 0.
  - bit counter = WIDTH-1, so the first cycle after reset is a load cycle.
  - holding buffer empty; in_ready = 1.
  - word_start = 0; underrun = 0.
- Bit counter:
  - counts 0..WIDTH-1 and wraps to 0.
  - load cycle = counter at WIDTH-1.
  - counter width is clog2(WIDTH), minimum 1.
- Shift:
  - each non-load cycle, every lane shifts one position toward its output end.
  - LSB_FIRST=1: shifts right, output is bit 0.
  - LSB_FIRST=0: shifts left, output is bit WIDTH-1.
  - vacated bit is filled with 0.
- Load, at the load cycle, by priority:
  - holding buffer full: load buffer into the shift registers; buffer becomes empty.
  - else if in_valid: load in_data directly (bypass); the handshake completes this cycle.
  - else: load IDLE_WORD into every lane and set underrun.
- Handshake:
  - in_ready = !hold_full, combinational from state only and independent of in_valid.
  - accept = in_valid && in_ready.
  - Accept on a non-load cycle: word goes into the holding buffer.
  - Accept on a load cycle with empty buffer: bypass as above; buffer stays empty.
  - Buffer full at a load cycle: the buffer drains and in_ready is 1 on the next cycle. in_valid is ignored that cycle because in_ready=0.
- Latency:
  - A word accepted in cycle t appears on serial_out starting at the first cycle after the next load cycle at or after t.
  - Bypass case: serial_out shows the word's first bit at t+1.
  - Sustained throughput: one word per WIDTH cycles with no idle insertion, provided in_valid is held high.
- word_start:
  - registered; 1 in the cycle after each load cycle, aligned with the first bit on serial_out.
  - also 1 for idle words.
- underrun:
  - set on an idle load; cleared by underrun_clr.
  - Simultaneous set and clear: set wins.
  - The first load after reset with in_valid=0 counts as an underrun.
- Reset mid-word: output is immediately 0, any partial word is discarded, and the buffer is emptied.
- Lanes never slip relative to one another; all share the one counter and load strobe.

Decomposition:
- Package hdmi_serdes_pkg holds:
  - the four TMDS control tokens, CTRL_00 through CTRL_11. IDLE_WORD defaults to CTRL_00.
  - the DEFAULT_WIDTH and DEFAULT_CHANNELS constants.
- Sub-module piso_lane: one lane's shift register.
  - parameters WIDTH and LSB_FIRST.
  - ports clk, rst_n, load, data_in, serial_out.
  - instantiated CHANNELS times with a generate loop.
- Counter, holding buffer, handshake and flag logic live in the top module.

Test Plan:
1. Reset, then in_valid=0 for 30 cycles -> each lane sends IDLE_WORD (1101010100) LSB first: 0,0,1,0,1,0,1,0,1,1, repeating. word_start at cycles 1, 11 and 21; underrun=1 from cycle 1.
2. in_valid held 1 with lane words 0x3FF/0x000/0x155, refreshed each accept -> no idle insertion over 100 words; underrun stays 0 after underrun_clr. One accept per 10 cycles in steady state; in_ready toggles as expected.
3. Accept on a non-load cycle (counter=3) with word 0x2AA -> in_ready drops the next cycle. Word is sent after the current word; in_ready returns 1 the cycle after the load.
4. LSB_FIRST=0, word 0x200 on lane 0 -> serial_out[0] = 1 on the word_start cycle, then 0 for 9 cycles.
5. Assert rst_n low at bit 4 of a word with the buffer full -> serial_out=0 and in_ready=1 immediately. After release the pending word is never transmitted, and the first load is idle.
6. underrun_clr=1 in the same cycle as an idle load -> underrun remains 1. A clear on a later cycle with data flowing -> underrun reads 0.

Source files
------------

// File: rtl/hdmi_serdes_pkg.sv
// Shared constants and types for the HDMI transmitter serialiser path.
// Holds the TMDS control tokens and the default lane geometry.
package hdmi_serdes_pkg;

  localparam int unsigned DEFAULT_WIDTH    = 10;
  localparam int unsigned DEFAULT_CHANNELS = 3;

  // TMDS control-period tokens, indexed by {C1, C0}.
  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_e;

endpackage

// File: rtl/multi_lane_serializer_piso_lane.sv
// One lane of the serialiser: a WIDTH-bit parallel-in serial-out shift register.
// The load strobe comes from the shared counter in the parent so lanes stay aligned.
module piso_lane #(
  parameter int unsigned WIDTH     = 10,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data_in;
    end else if (LSB_FIRST) begin
      sreg <= {1'b0, sreg[WIDTH-1:1]};
    end else begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign serial_out = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];

endmodule

// File: rtl/multi_lane_serializer.sv
// Lock-step multi-lane PISO serialiser with a valid/ready input, one-entry holding
// buffer, self-generated word-boundary load strobe and idle-word insertion on underrun.
module multi_lane_serializer
  import hdmi_serdes_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned      CHANNELS  = DEFAULT_CHANNELS,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(CTRL_00)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  output logic [CHANNELS-1:0]         serial_out,
  output logic                        word_start,
  output logic                        underrun,
  input  logic                        underrun_clr
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [CW-1:0]               bit_cnt;
  logic                        load;
  logic                        accept;
  logic                        idle_load;
  hold_state_e                 hold_state;
  hold_state_e                 hold_next;
  logic [CHANNELS*WIDTH-1:0]   hold_data;
  logic [CHANNELS*WIDTH-1:0]   load_data;

  // Counter resets to the last bit so the first cycle out of reset is a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= LAST;
    end else if (load) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  assign load   = (bit_cnt == LAST);
  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_state <= HOLD_EMPTY;
    end else begin
      hold_state <= hold_next;
    end
  end

  // An accept on a load cycle bypasses the buffer, so only non-load accepts fill it.
  always_comb begin
    hold_next = hold_state;
    unique case (hold_state)
      HOLD_EMPTY: if (accept && !load) hold_next = HOLD_FULL;
      HOLD_FULL:  if (load)            hold_next = HOLD_EMPTY;
      default:                         hold_next = HOLD_EMPTY;
    endcase
  end

  always_comb begin
    in_ready = (hold_state == HOLD_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
    end else if (accept && !load) begin
      hold_data <= in_data;
    end
  end

  always_comb begin
    load_data = {CHANNELS{IDLE_WORD}};
    idle_load = 1'b0;
    if (hold_state == HOLD_FULL) begin
      load_data = hold_data;
    end else if (in_valid) begin
      load_data = in_data;
    end else begin
      idle_load = load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_start <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      word_start <= load;
      if (idle_load) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    piso_lane #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .data_in    (load_data[k*WIDTH +: WIDTH]),
      .serial_out (serial_out[k])
    );
  end

endmodule

// File: tb/tb_multi_lane_serializer.sv
// Directed bench for multi_lane_serializer: accepted words are queued as expected
// transmissions and compared bit-by-bit against serial_out as the DUT emits them.
module tb_multi_lane_serializer;

  localparam int unsigned W  = 10;
  localparam int unsigned CH = 3;
  localparam logic [W-1:0] IDLE = 10'b1101010100;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CH*W-1:0]  in_data;
  logic [CH-1:0]    serial_out;
  logic             word_start;
  logic             underrun;
  logic             underrun_clr;

  logic             m_valid;
  logic             m_ready;
  logic [W-1:0]     m_data;
  logic [0:0]       m_serial;
  logic             m_ws;
  logic             m_under;
  logic             m_clr;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  // Bench model: the queue doubles as the holding buffer.
  logic [CH*W-1:0] sbq[$];
  logic [CH*W-1:0] cur;
  bit              cur_valid;
  bit              mws;
  bit              munder;
  int unsigned     mcnt;
  bit              last_dut_acc;

  always #5 clk = ~clk;

  multi_lane_serializer #(
    .WIDTH     (W),
    .CHANNELS  (CH),
    .LSB_FIRST (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .serial_out   (serial_out),
    .word_start   (word_start),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  multi_lane_serializer #(
    .WIDTH     (W),
    .CHANNELS  (1),
    .LSB_FIRST (1'b0)
  ) dut_msb (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (m_valid),
    .in_ready     (m_ready),
    .in_data      (m_data),
    .serial_out   (m_serial),
    .word_start   (m_ws),
    .underrun     (m_under),
    .underrun_clr (m_clr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] set_word(input int unsigned n);
    logic [CH*W-1:0] base;
    base = {10'h155, 10'h000, 10'h3FF};
    return (n % 2 == 1) ? ~base : base;
  endfunction

  task automatic model_reset();
    sbq.delete();
    mcnt      = W - 1;
    cur       = '0;
    cur_valid = 1'b0;
    mws       = 1'b0;
    munder    = 1'b0;
  endtask

  // One clock: predict, advance, then compare everything the main DUT drives.
  task automatic step();
    bit exp_ready;
    bit idle;
    logic [CH-1:0] exp_ser;
    exp_ready = (sbq.size() == 0);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    last_dut_acc = in_valid && in_ready;
    if (in_valid && exp_ready) sbq.push_back(in_data);
    idle = 1'b0;
    if (mcnt == W - 1) begin
      if (sbq.size() > 0) begin
        cur = sbq.pop_front();
      end else begin
        cur  = {CH{IDLE}};
        idle = 1'b1;
      end
      cur_valid = 1'b1;
      mws       = 1'b1;
      mcnt      = 0;
    end else begin
      mws  = 1'b0;
      mcnt = mcnt + 1;
    end
    if (idle) munder = 1'b1;
    else if (underrun_clr) munder = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < CH; k++) exp_ser[k] = cur_valid ? cur[k*W + mcnt] : 1'b0;
    chk("serial_out", 32'(serial_out), 32'(exp_ser));
    chk("word_start", 32'(word_start), 32'(mws));
    chk("underrun", 32'(underrun), 32'(munder));
  endtask

  task automatic wait_cnt(input int unsigned target);
    int unsigned n = 0;
    while (mcnt != target && n < 2 * W) begin
      step();
      n++;
    end
    if (mcnt != target) begin
      fails++;
      $error("FAIL wait_cnt observed=%0d expected=%0d", mcnt, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] cap;
    int unsigned acc_n;
    int unsigned t;
    int unsigned last_t;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; underrun_clr = 1'b0;
    m_valid = 1'b0; m_data = '0; m_clr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #3;
    chk("rst_serial", 32'(serial_out), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    chk("rst_word_start", 32'(word_start), 32'(0));
    chk("rst_underrun", 32'(underrun), 32'(0));
    rst_n = 1'b1;

    // Idle stream straight out of reset.
    cap = '0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i <= 10) cap[i-1] = serial_out[0];
      if (i == 1 || i == 11 || i == 21) chk("idle_word_start", 32'(word_start), 32'(1));
    end
    chk("idle_pattern", 32'(cap), 32'(IDLE));
    chk("idle_underrun", 32'(underrun), 32'(1));

    // Sustained traffic with a clear at the start.
    acc_n = 0; t = 0; last_t = 0;
    in_valid = 1'b1;
    in_data  = set_word(0);
    while (acc_n < 100 && t < 1200) begin
      underrun_clr = (t == 0);
      step();
      t++;
      if (last_dut_acc) begin
        acc_n++;
        if (acc_n >= 3) chk("accept_gap", 32'(t - last_t), 32'(10));
        last_t  = t;
        in_data = set_word(acc_n);
      end
    end
    underrun_clr = 1'b0;
    chk("stream_accepts", 32'(acc_n), 32'(100));
    chk("stream_underrun", 32'(underrun), 32'(0));
    in_valid = 1'b0;
    repeat (20) step();

    // Accept on a non-load cycle lands in the buffer.
    wait_cnt(3);
    in_valid = 1'b1;
    in_data  = {CH{10'h2AA}};
    step();
    in_valid = 1'b0;
    chk("buf_ready_drop", 32'(in_ready), 32'(0));
    wait_cnt(0);
    chk("buf_ready_back", 32'(in_ready), 32'(1));
    repeat (12) step();

    // Reset at bit 4 with a word pending in the buffer.
    wait_cnt(1);
    in_valid = 1'b1;
    in_data  = {CH{10'h0F3}};
    step();
    in_valid = 1'b0;
    wait_cnt(4);
    chk("pre_rst_ready", 32'(in_ready), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_serial", 32'(serial_out), 32'(0));
    chk("midrst_ready", 32'(in_ready), 32'(1));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_underrun", 32'(underrun), 32'(1));
    repeat (24) step();

    // Clear coinciding with an idle load loses to the set.
    wait_cnt(9);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("clr_vs_set", 32'(underrun), 32'(1));
    in_valid = 1'b1;
    in_data  = {10'h011, 10'h222, 10'h3C5};
    repeat (5) step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("clr_later", 32'(underrun), 32'(0));
    repeat (20) step();
    in_valid = 1'b0;
    repeat (15) step();

    // MSB-first lane.
    wait_cnt(9);
    chk("msb_ready", 32'(m_ready), 32'(1));
    m_valid = 1'b1;
    m_data  = 10'h200;
    step();
    m_valid = 1'b0;
    chk("msb_first_bit", 32'(m_serial), 32'(1));
    chk("msb_word_start", 32'(m_ws), 32'(1));
    for (int i = 0; i < 9; i++) begin
      step();
      chk("msb_rest", 32'(m_serial), 32'(0));
      chk("msb_ws_low", 32'(m_ws), 32'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
